// File: rtl/ux607_icache_pkg.sv
// Shared types and sizing helpers for the I-cache refill write path.
package ux607_icache_pkg;

    localparam int unsigned IDXW_DEF  = 6;
    localparam int unsigned BEATS_DEF = 4;
    localparam int unsigned DW_DEF    = 64;
    localparam int unsigned MW_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // RAM address = {line index, beat offset}
    function automatic int unsigned addr_w(input int unsigned idxw, input int unsigned beats);
        return idxw + $unsigned($clog2(beats));
    endfunction

endpackage

// File: rtl/ux607_icache_refill_wr_if.sv
// Refill, fetch-read and RAM-macro signals of the I-cache data RAM write front end.
interface ux607_icache_refill_wr_if #(
    parameter int unsigned IDXW  = ux607_icache_pkg::IDXW_DEF,
    parameter int unsigned BEATS = ux607_icache_pkg::BEATS_DEF,
    parameter int unsigned DW    = ux607_icache_pkg::DW_DEF,
    parameter int unsigned MW    = ux607_icache_pkg::MW_DEF
);
    localparam int unsigned AW = ux607_icache_pkg::addr_w(IDXW, BEATS);

    logic            fill_start;
    logic [IDXW-1:0] fill_idx;
    logic            beat_valid;
    logic            beat_ready;
    logic [DW-1:0]   beat_data;
    logic            beat_err;
    logic            fill_done;
    logic            fill_err;
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_gnt;
    logic            rd_rsp_valid;
    logic [DW-1:0]   rd_rsp_data;
    logic            ram_cs;
    logic [AW-1:0]   ram_addr;
    logic [MW-1:0]   ram_wem;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;

    modport slave (
        input  fill_start, fill_idx, beat_valid, beat_data, beat_err, rd_req, rd_addr, ram_dout,
        output beat_ready, fill_done, fill_err, rd_gnt, rd_rsp_valid, rd_rsp_data,
               ram_cs, ram_addr, ram_wem, ram_din
    );

    modport master (
        output fill_start, fill_idx, beat_valid, beat_data, beat_err, rd_req, rd_addr, ram_dout,
        input  beat_ready, fill_done, fill_err, rd_gnt, rd_rsp_valid, rd_rsp_data,
               ram_cs, ram_addr, ram_wem, ram_din
    );

endinterface

// File: rtl/ux607_icache_refill_fifo.sv
// Two-entry valid/ready FIFO holding refill beats ({err,data}) until the RAM is free.
module ux607_icache_refill_fifo #(
    parameter int unsigned W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data,
    output logic         o_full
);
    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_full      = (r_cnt == 2'd2);
    assign o_out_valid = (r_cnt != 2'd0);
    assign o_out_data  = r_mem[r_rptr];
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign o_in_ready  = !o_full || i_out_ready;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = i_out_ready && o_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_in_data;
    end

endmodule

// File: rtl/ux607_icache_refill_wr.sv
// I-cache data RAM write front end: buffers refill beats, sequences line-fill writes and
// shares the single-port RAM with fetch reads.
module ux607_icache_refill_wr
    import ux607_icache_pkg::*;
#(
    parameter int unsigned IDXW  = IDXW_DEF,
    parameter int unsigned BEATS = BEATS_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned MW    = MW_DEF
) (
    input logic                     clk,
    input logic                     rst,
    ux607_icache_refill_wr_if.slave bus
);
    localparam int unsigned AW  = addr_w(IDXW, BEATS);
    localparam int unsigned CW  = $clog2(BEATS);
    localparam int unsigned ACW = CW + 1;
    localparam int unsigned FW  = DW + 1;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [IDXW-1:0] r_fill_idx;
    logic [CW-1:0]   r_beat_cnt;
    logic [ACW-1:0]  r_acc_cnt;
    logic            r_err;
    logic            r_rsp_valid;
    logic [AW-1:0]   r_ram_addr;
    logic [DW-1:0]   r_ram_din;

    logic            w_beat_ready;
    logic            w_fill_done;
    logic            w_fill_err;
    logic            w_push;
    logic            w_pop;
    logic            w_rd_gnt;
    logic            w_last_wr;
    logic            w_ram_cs;
    logic [AW-1:0]   w_ram_addr;
    logic [DW-1:0]   w_ram_din;
    logic            w_fifo_in_ready;
    logic            w_fifo_out_valid;
    logic            w_fifo_full;
    logic [FW-1:0]   w_fifo_head;

    ux607_icache_refill_fifo #(.W(FW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (w_push),
        .o_in_ready  (w_fifo_in_ready),
        .i_in_data   ({bus.beat_err, bus.beat_data}),
        .o_out_valid (w_fifo_out_valid),
        .i_out_ready (w_pop),
        .o_out_data  (w_fifo_head),
        .o_full      (w_fifo_full)
    );

    // Arbiter: a full FIFO must drain, otherwise fetch reads take priority.
    assign w_rd_gnt   = bus.rd_req && !w_fifo_full;
    assign w_pop      = w_fifo_out_valid && !w_rd_gnt;
    assign w_push     = bus.beat_valid && w_beat_ready && w_fifo_in_ready;
    assign w_last_wr  = w_pop && (r_beat_cnt == CW'(BEATS - 1));
    assign w_ram_cs   = w_pop || w_rd_gnt;
    assign w_ram_addr = w_pop ? {r_fill_idx, r_beat_cnt} : (w_rd_gnt ? bus.rd_addr : r_ram_addr);
    assign w_ram_din  = w_pop ? w_fifo_head[DW-1:0] : r_ram_din;

    always_comb begin
        w_state_nxt  = r_state;
        w_beat_ready = 1'b0;
        w_fill_done  = 1'b0;
        w_fill_err   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.fill_start) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                w_beat_ready = !w_fifo_full && (r_acc_cnt < ACW'(BEATS));
                if (w_last_wr) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_fill_done = 1'b1;
                w_fill_err  = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_idx  <= '0;
            r_beat_cnt  <= '0;
            r_acc_cnt   <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && bus.fill_start) begin
                r_fill_idx <= bus.fill_idx;
                r_beat_cnt <= '0;
                r_acc_cnt  <= '0;
            end
            if (w_push) r_acc_cnt <= r_acc_cnt + ACW'(1);
            // errored beats are still written; the cache FSM invalidates the line
            if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + CW'(1);
                if (w_fifo_head[DW]) r_err <= 1'b1;
            end
            if (r_state == ST_DONE) r_err <= 1'b0;
            r_rsp_valid <= w_rd_gnt;
            if (w_ram_cs) r_ram_addr <= w_ram_addr;
            if (w_pop)    r_ram_din  <= w_ram_din;
        end
    end

    assign bus.beat_ready   = w_beat_ready;
    assign bus.fill_done    = w_fill_done;
    assign bus.fill_err     = w_fill_err;
    assign bus.rd_gnt       = w_rd_gnt;
    assign bus.rd_rsp_valid = r_rsp_valid;
    assign bus.rd_rsp_data  = bus.ram_dout;
    assign bus.ram_cs       = w_ram_cs;
    assign bus.ram_addr     = w_ram_addr;
    assign bus.ram_wem      = w_pop ? {MW{1'b1}} : {MW{1'b0}};
    assign bus.ram_din      = w_ram_din;

endmodule

// File: tb/tb_ux607_icache_refill_wr.sv
// Directed bench for ux607_icache_refill_wr with a queue-based reference model and RAM model.
module tb_ux607_icache_refill_wr;
    localparam int unsigned IDXW  = 6;
    localparam int unsigned BEATS = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned MW    = 8;
    localparam int unsigned AW    = 8;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    ux607_icache_refill_wr_if #(.IDXW(IDXW), .BEATS(BEATS), .DW(DW), .MW(MW)) bus ();

    ux607_icache_refill_wr #(.IDXW(IDXW), .BEATS(BEATS), .DW(DW), .MW(MW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro model, 1-cycle read latency; 0x15 preloaded during reset
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (rst) mem[AW'(21)] <= 64'hDEAD;
        if (bus.ram_cs) begin
            if (bus.ram_wem != '0) mem[bus.ram_addr] <= bus.ram_din;
            else                   bus.ram_dout      <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: accepted-but-unwritten beats live in m_q with their target address.
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic err; } beat_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_t;
    beat_t           m_q[$];
    wr_t             wlog[$];
    bit              m_fill, m_done, m_err, m_rsp_pend;
    int              m_acc, m_wr;
    logic [IDXW-1:0] m_idx;
    logic [AW-1:0]   m_rsp_addr;
    int              cyc = 0, n_done = 0, done_cyc = 0, gap = 0, wreq = 0;
    logic            done_err = 1'b0;

    always @(negedge clk) begin
        bit    e_rdy, e_gnt, e_wr;
        beat_t b;
        wr_t   w;
        cyc++;
        if (rst) begin
            m_q.delete();
            m_fill = 0; m_done = 0; m_err = 0; m_rsp_pend = 0; m_acc = 0; m_wr = 0;
        end else begin
            e_rdy = m_fill && (m_q.size() < 2) && (m_acc < BEATS);
            e_gnt = bus.rd_req && (m_q.size() < 2);
            e_wr  = (m_q.size() == 2) || (!bus.rd_req && (m_q.size() != 0));
            chk("beat_ready", 64'(bus.beat_ready), 64'(e_rdy));
            chk("rd_gnt", 64'(bus.rd_gnt), 64'(e_gnt));
            chk("ram_cs", 64'(bus.ram_cs), 64'(e_wr || e_gnt));
            chk("ram_wem", 64'(bus.ram_wem), e_wr ? 64'(8'hFF) : 64'd0);
            if (e_wr) begin
                chk("wr_addr", 64'(bus.ram_addr), 64'(m_q[0].addr));
                chk("wr_data", bus.ram_din, m_q[0].data);
            end else if (e_gnt) begin
                chk("rd_addr", 64'(bus.ram_addr), 64'(bus.rd_addr));
            end
            chk("fill_done", 64'(bus.fill_done), 64'(m_done));
            chk("fill_err", 64'(bus.fill_err), 64'(m_done && m_err));
            chk("rd_rsp_valid", 64'(bus.rd_rsp_valid), 64'(m_rsp_pend));
            if (m_rsp_pend) chk("rd_rsp_data", bus.rd_rsp_data, mem[m_rsp_addr]);

            if (bus.ram_cs && (bus.ram_wem != '0)) begin
                w.addr = bus.ram_addr; w.data = bus.ram_din; w.cyc = cyc;
                wlog.push_back(w);
            end
            if (bus.fill_done) begin n_done++; done_cyc = cyc; done_err = bus.fill_err; end
            if (bus.rd_req && !bus.rd_gnt) gap++;
            if (bus.rd_req && bus.ram_cs && (bus.ram_wem != '0)) wreq++;

            m_rsp_pend = e_gnt;
            m_rsp_addr = bus.rd_addr;
            if (m_done) begin
                m_done = 0; m_err = 0;
            end else if (!m_fill && bus.fill_start) begin
                m_fill = 1; m_idx = bus.fill_idx; m_acc = 0; m_wr = 0;
            end
            if (e_wr) begin
                m_err = m_err | m_q[0].err;
                void'(m_q.pop_front());
                m_wr++;
                if (m_wr == BEATS) begin m_fill = 0; m_done = 1; end
            end
            if (e_rdy && bus.beat_valid) begin
                b.addr = AW'(int'(m_idx) * BEATS + m_acc);
                b.data = bus.beat_data; b.err = bus.beat_err;
                m_q.push_back(b);
                m_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_fill(input int idx);
        bus.fill_start = 1'b1; bus.fill_idx = IDXW'(idx);
        tick();
        bus.fill_start = 1'b0;
    endtask

    // Offers n beats back-to-back; beat number err_beat carries beat_err.
    task automatic offer_beats(input int n, input logic [DW-1:0] base, input int err_beat);
        int  i = 0;
        int  t = 0;
        bit  acc;
        while (i < n && t < 64) begin
            bus.beat_valid = 1'b1; bus.beat_data = base + DW'(i); bus.beat_err = (i == err_beat);
            @(negedge clk); acc = bus.beat_ready;
            tick();
            if (acc) i++;
            t++;
        end
        bus.beat_valid = 1'b0; bus.beat_err = 1'b0;
        chk("beats_accepted", 64'(i), 64'(n));
    endtask

    task automatic wait_done(input int tgt);
        int t = 0;
        while (n_done < tgt && t < 100) begin tick(); t++; end
        chk("fill_done_seen", 64'(n_done), 64'(tgt));
    endtask

    task automatic check_fill(input int w0, input int base_addr, input logic [DW-1:0] base_data);
        chk("fill_nwr", 64'(wlog.size() - w0), 64'(BEATS));
        if (wlog.size() >= w0 + BEATS)
            for (int k = 0; k < BEATS; k++) begin
                chk("fill_addr", 64'(wlog[w0+k].addr), 64'(base_addr + k));
                chk("fill_data", wlog[w0+k].data, base_data + DW'(k));
            end
    endtask

    initial begin
        int w0, d0, g0, r0;
        rst = 1'b1;
        bus.fill_start = 1'b0; bus.fill_idx = '0; bus.beat_valid = 1'b0; bus.beat_data = '0;
        bus.beat_err = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_beat_ready", 64'(bus.beat_ready), 0);
        chk("rst_fill_done", 64'(bus.fill_done), 0);
        chk("rst_fill_err", 64'(bus.fill_err), 0);
        chk("rst_rsp_valid", 64'(bus.rd_rsp_valid), 0);
        chk("rst_ram_cs", 64'(bus.ram_cs), 0);
        chk("rst_ram_wem", 64'(bus.ram_wem), 0);
        chk("rst_ram_addr", 64'(bus.ram_addr), 0);
        chk("rst_ram_din", bus.ram_din, 0);
        tick();

        // preloaded read: grant same cycle, data next cycle
        bus.rd_req = 1'b1; bus.rd_addr = AW'(8'h15);
        @(negedge clk); chk("t3_gnt", 64'(bus.rd_gnt), 1);
        tick();
        bus.rd_req = 1'b0;
        @(negedge clk);
        chk("t3_rsp_valid", 64'(bus.rd_rsp_valid), 1);
        chk("t3_rsp_data", bus.rd_rsp_data, 64'hDEAD);
        tick();

        // plain fill of line 5, no reads
        w0 = wlog.size(); d0 = n_done;
        start_fill(5);
        offer_beats(4, 64'hA0, 99);
        wait_done(d0 + 1);
        check_fill(w0, 20, 64'hA0);
        if (wlog.size() >= w0 + 4) chk("t1_done_lat", 64'(done_cyc - wlog[w0+3].cyc), 1);
        chk("t1_err", 64'(done_err), 0);

        // fill of line 2 under continuous reads, plus a 5th beat and a stray fill_start
        w0 = wlog.size(); d0 = n_done; g0 = gap; r0 = wreq;
        bus.rd_req = 1'b1; bus.rd_addr = AW'(3);
        start_fill(2);
        offer_beats(4, 64'hB0, 99);
        bus.beat_valid = 1'b1; bus.beat_data = 64'hB4; bus.fill_start = 1'b1; bus.fill_idx = IDXW'(12);
        repeat (4) begin
            @(negedge clk); chk("t5_no_5th_beat", 64'(bus.beat_ready), 0);
            tick();
        end
        bus.beat_valid = 1'b0; bus.fill_start = 1'b0;
        chk("t2_gaps", 64'(gap - g0), 3);
        chk("t2_wr_under_req", 64'(wreq - r0), 3);
        // only a full FIFO preempts reads, so the last beat waits for rd_req to drop
        bus.rd_req = 1'b0;
        wait_done(d0 + 1);
        check_fill(w0, 8, 64'hB0);
        chk("t2_err", 64'(done_err), 0);
        tick();

        // error on beat 2, then a clean fill
        w0 = wlog.size(); d0 = n_done;
        start_fill(7);
        offer_beats(4, 64'hC0, 2);
        wait_done(d0 + 1);
        check_fill(w0, 28, 64'hC0);
        chk("t4_err", 64'(done_err), 1);
        w0 = wlog.size();
        start_fill(8);
        offer_beats(4, 64'hD0, 99);
        wait_done(d0 + 2);
        check_fill(w0, 32, 64'hD0);
        chk("t4_err_cleared", 64'(done_err), 0);
        tick();

        // reset in the middle of a fill
        d0 = n_done;
        start_fill(3);
        bus.beat_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin bus.beat_data = 64'hE0 + DW'(k); tick(); end
        bus.beat_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_beat_ready", 64'(bus.beat_ready), 0);
        chk("t6_fill_done", 64'(bus.fill_done), 0);
        tick();
        repeat (5) tick();
        chk("t6_no_done", 64'(n_done), 64'(d0));
        w0 = wlog.size();
        start_fill(4);
        offer_beats(4, 64'hF0, 99);
        wait_done(d0 + 1);
        check_fill(w0, 16, 64'hF0);
        chk("t6_err", 64'(done_err), 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
